multi_button_pulser: RTL and testbench

//  Per-channel pushbutton conditioner: synchroniser, debounce, edge-to-single-pulse and optional auto-repeat.

---
 rtl/multi_button_pulser.sv | 119 +++++++++++
 tb/tb_multi_button_pulser.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_button_pulser.sv
// rtl/multi_button_pulser.sv - per-channel button synchroniser, debouncer, edge pulser and auto-repeat
//
// Purpose: conditions N_CH raw pushbuttons into clean single-cycle pulses,
// one per qualified press/release (selected by EDGE_MODE), plus optional
// timed auto-repeat pulses while a button stays pressed.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   en         1 = pulses enabled; 0 = pulse/any_pulse forced low (state keeps running)
//   btn        raw asynchronous button inputs, active-high
//   level      debounced level per channel
//   pulse      one-cycle pulse per qualified event per channel
//   any_pulse  OR of pulse, same cycle
//   first_ch   lowest-index channel with pulse set this cycle, 0 when none
module multi_button_pulser #(
  parameter int N_CH            = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_EN       = 0,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 8,
  localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pulse,
  output logic            any_pulse,
  output logic [CH_W-1:0] first_ch
);

  localparam int MAX_RC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int REP_W  = $clog2(MAX_RC + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q  [N_CH];
  logic [DB_W-1:0]        db_cnt  [N_CH];
  // Cycles remaining until the next repeat pulse; 0 means no repeat armed.
  logic [REP_W-1:0]       rep_cnt [N_CH];
  logic [N_CH-1:0]        prev;

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] sel;
  logic [N_CH-1:0] rep_fire;
  logic [N_CH-1:0] ev;
  logic [CH_W-1:0] first_nxt;

  always_comb begin
    rise = level & ~prev;
    fall = ~level & prev;
    case (EDGE_MODE)
      1:       sel = fall;
      2:       sel = rise | fall;
      default: sel = rise;
    endcase
    // A repeat only fires while the debounced level is still high, so a
    // repeat falling due on the fall-pulse cycle is dropped.
    for (int i = 0; i < N_CH; i++) begin
      rep_fire[i] = (REPEAT_EN != 0) && level[i] && !rise[i] && (rep_cnt[i] == REP_W'(1));
    end
    ev = (sel | rep_fire) & {N_CH{en}};
    first_nxt = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ev[i]) first_nxt = CH_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i]  <= '0;
        db_cnt[i]  <= '0;
        rep_cnt[i] <= '0;
      end
      level     <= '0;
      prev      <= '0;
      pulse     <= '0;
      any_pulse <= 1'b0;
      first_ch  <= '0;
    end else begin
      prev      <= level;
      pulse     <= ev;
      any_pulse <= |ev;
      first_ch  <= first_nxt;
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn[i]};

        // Any agreeing sample restarts the count, rejecting short glitches.
        if (sync_q[i][SYNC_STAGES-1] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync_q[i][SYNC_STAGES-1];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end

        // Repeat timing is armed by the rise edge in every EDGE_MODE.
        if (REPEAT_EN == 0) begin
          rep_cnt[i] <= '0;
        end else if (rise[i]) begin
          rep_cnt[i] <= REP_W'(HOLD_CYCLES);
        end else if (!level[i]) begin
          rep_cnt[i] <= '0;
        end else if (rep_cnt[i] == REP_W'(1)) begin
          rep_cnt[i] <= REP_W'(REPEAT_CYCLES);
        end else if (rep_cnt[i] != '0) begin
          rep_cnt[i] <= rep_cnt[i] - REP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_button_pulser.sv
// tb/tb_multi_button_pulser.sv - self-checking bench for multi_button_pulser
module tb_multi_button_pulser;

  localparam int HOLD = 16;
  localparam int REPC = 8;
  localparam int DEB  = 4;
  localparam int SYN  = 2;
  localparam int MODE  [4] = '{0, 1, 2, 0};
  localparam int REPEN [4] = '{0, 0, 0, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [1:0] btn = 2'b00;

  logic [1:0] lvl  [4];
  logic [1:0] pls  [4];
  logic       anyp [4];
  logic [0:0] fc   [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_button_pulser #(.N_CH(2), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0),
    .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPC)) u0 (
    .clk(clk), .rst(rst), .en(en), .btn(btn), .level(lvl[0]), .pulse(pls[0]),
    .any_pulse(anyp[0]), .first_ch(fc[0]));
  multi_button_pulser #(.N_CH(2), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(1),
    .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPC)) u1 (
    .clk(clk), .rst(rst), .en(en), .btn(btn), .level(lvl[1]), .pulse(pls[1]),
    .any_pulse(anyp[1]), .first_ch(fc[1]));
  multi_button_pulser #(.N_CH(2), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(2),
    .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPC)) u2 (
    .clk(clk), .rst(rst), .en(en), .btn(btn), .level(lvl[2]), .pulse(pls[2]),
    .any_pulse(anyp[2]), .first_ch(fc[2]));
  multi_button_pulser #(.N_CH(2), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0),
    .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPC)) u3 (
    .clk(clk), .rst(rst), .en(en), .btn(btn), .level(lvl[3]), .pulse(pls[3]),
    .any_pulse(anyp[3]), .first_ch(fc[3]));

  // Reference model: raw samples delayed SYN cycles, level flips once the
  // last DEB samples all disagree, events derived from level history,
  // repeats from elapsed-time arithmetic since the press pulse.
  bit         m_bq   [2][SYN];
  bit         m_sq   [2][DEB];
  bit         m_lvl  [2];
  bit         m_rf   [2];
  bit         m_ff   [2];
  int         m_since[2];
  int         m_t    [2];
  bit         m_act  [2];
  logic [1:0] e_pulse[4];
  logic       e_first[4];

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      for (int j = 0; j < SYN; j++) m_bq[ch][j] = 1'b0;
      for (int j = 0; j < DEB; j++) m_sq[ch][j] = 1'b0;
      m_lvl[ch] = 1'b0; m_rf[ch] = 1'b0; m_ff[ch] = 1'b0;
      m_since[ch] = 0; m_t[ch] = 0; m_act[ch] = 1'b0;
    end
    for (int c = 0; c < 4; c++) begin
      e_pulse[c] = 2'b00;
      e_first[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit rise_ev [2];
    bit fall_ev [2];
    bit fire    [2];
    bit s_now, all_dis, flip, sel;
    for (int ch = 0; ch < 2; ch++) begin
      s_now = m_bq[ch][SYN-1];
      for (int j = SYN - 1; j > 0; j--) m_bq[ch][j] = m_bq[ch][j-1];
      m_bq[ch][0] = btn[ch];
      for (int j = DEB - 1; j > 0; j--) m_sq[ch][j] = m_sq[ch][j-1];
      m_sq[ch][0] = s_now;
      m_since[ch]++;
      rise_ev[ch] = m_rf[ch];
      fall_ev[ch] = m_ff[ch];
      fire[ch] = 1'b0;
      if (rise_ev[ch]) begin
        m_t[ch] = 0; m_act[ch] = 1'b1;
      end else if (m_act[ch] && m_lvl[ch]) begin
        m_t[ch]++;
        fire[ch] = (m_t[ch] == HOLD) || (m_t[ch] > HOLD && ((m_t[ch] - HOLD) % REPC) == 0);
      end else begin
        m_act[ch] = 1'b0;
      end
      all_dis = 1'b1;
      for (int j = 0; j < DEB; j++) if (m_sq[ch][j] == m_lvl[ch]) all_dis = 1'b0;
      flip = (m_since[ch] >= DEB) && all_dis;
      m_rf[ch] = flip && !m_lvl[ch];
      m_ff[ch] = flip && m_lvl[ch];
      if (flip) begin
        m_lvl[ch] = !m_lvl[ch];
        m_since[ch] = 0;
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        case (MODE[c])
          1:       sel = fall_ev[ch];
          2:       sel = rise_ev[ch] | fall_ev[ch];
          default: sel = rise_ev[ch];
        endcase
        e_pulse[c][ch] = en && (sel || (REPEN[c] != 0 && fire[ch]));
      end
      e_first[c] = e_pulse[c][0] ? 1'b0 : e_pulse[c][1];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  function automatic logic [5:0] obs_vec(int c);
    return {lvl[c], pls[c], anyp[c], fc[c]};
  endfunction

  function automatic logic [5:0] exp_vec(int c);
    return {m_lvl[1], m_lvl[0], e_pulse[c], |e_pulse[c], e_first[c]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    btn = 2'b00; en = 1'b1; rst = 1'b1;
    model_reset();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (obs_vec(c) !== 6'b0) begin
        n_err++;
        $display("FAIL reset_state u%0d: got %b want %b", c, obs_vec(c), 6'b0);
      end
    end
  endtask

  task automatic test_single_press();
    int first_p = -1;
    int n_p = 0;
    int lvl_at = -1;
    do_reset();
    btn = 2'b01;
    for (int k = 1; k <= 50; k++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (obs_vec(c) !== exp_vec(c)) begin
          n_err++;
          $display("FAIL single_press u%0d cyc%0d: got %b want %b", c, k, obs_vec(c), exp_vec(c));
        end
      end
      if (pls[0][0]) begin n_p++; if (first_p < 0) first_p = k; end
      if (lvl[0][0] && lvl_at < 0) lvl_at = k;
    end
    n_cmp++;
    if (first_p !== 7 || n_p !== 1) begin
      n_err++;
      $display("FAIL press_latency: got first=%0d count=%0d want first=7 count=1", first_p, n_p);
    end
    n_cmp++;
    if (lvl_at !== 6) begin
      n_err++;
      $display("FAIL level_latency: got %0d want 6", lvl_at);
    end
  endtask

  task automatic test_bounce();
    bit pat[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    int n_p = 0;
    int lvl_at = -1;
    do_reset();
    for (int k = 0; k < 63; k++) begin
      btn[1] = (k < 8) ? pat[k] : (k < 38);
      tick();
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (obs_vec(c) !== exp_vec(c)) begin
          n_err++;
          $display("FAIL bounce u%0d cyc%0d: got %b want %b", c, k + 1, obs_vec(c), exp_vec(c));
        end
      end
      if (pls[0][1]) n_p++;
      if (lvl[0][1] && lvl_at < 0) lvl_at = k + 1;
    end
    n_cmp++;
    if (n_p !== 1 || lvl_at !== 14) begin
      n_err++;
      $display("FAIL bounce_reject: got pulses=%0d level_at=%0d want pulses=1 level_at=14", n_p, lvl_at);
    end
  endtask

  task automatic test_edge_modes();
    int p2[$];
    int p1[$];
    do_reset();
    for (int k = 0; k < 45; k++) begin
      btn[0] = (k < 20);
      tick();
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (obs_vec(c) !== exp_vec(c)) begin
          n_err++;
          $display("FAIL edge_modes u%0d cyc%0d: got %b want %b", c, k + 1, obs_vec(c), exp_vec(c));
        end
      end
      if (pls[2][0]) p2.push_back(k + 1);
      if (pls[1][0]) p1.push_back(k + 1);
    end
    n_cmp++;
    if (p2.size() != 2 || p2[0] != 7 || p2[1] != 27) begin
      n_err++;
      $display("FAIL mode2_both: got %0d pulses first=%0d want 2 pulses at 7,27",
               p2.size(), (p2.size() > 0) ? p2[0] : -1);
    end
    n_cmp++;
    if (p1.size() != 1 || p1[0] != 27) begin
      n_err++;
      $display("FAIL mode1_release: got %0d pulses first=%0d want 1 pulse at 27",
               p1.size(), (p1.size() > 0) ? p1[0] : -1);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn = 2'b11;
    for (int k = 1; k <= 60; k++) begin
      if (k == 20) btn = 2'b00;
      if (k == 30) begin en = 1'b0; btn = 2'b11; end
      tick();
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (obs_vec(c) !== exp_vec(c)) begin
          n_err++;
          $display("FAIL simultaneous u%0d cyc%0d: got %b want %b", c, k, obs_vec(c), exp_vec(c));
        end
      end
      if (k == 7) begin
        n_cmp++;
        if ({pls[0], anyp[0], fc[0]} !== 4'b1110) begin
          n_err++;
          $display("FAIL both_rise: got %b want %b", {pls[0], anyp[0], fc[0]}, 4'b1110);
        end
      end
      if (k == 36) begin
        n_cmp++;
        if ({pls[0], lvl[0]} !== 4'b0011) begin
          n_err++;
          $display("FAIL en_low_drop: got %b want %b", {pls[0], lvl[0]}, 4'b0011);
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_repeat(input int rel_k, input int exp_n);
    int got[$];
    int want[7] = '{7, 23, 31, 39, 47, 55, 63};
    bit bad = 1'b0;
    do_reset();
    for (int k = 0; k < 95; k++) begin
      btn[0] = (k < rel_k);
      tick();
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (obs_vec(c) !== exp_vec(c)) begin
          n_err++;
          $display("FAIL repeat u%0d cyc%0d: got %b want %b", c, k + 1, obs_vec(c), exp_vec(c));
        end
      end
      if (pls[3][0]) got.push_back(k + 1);
    end
    if (got.size() != exp_n) bad = 1'b1;
    for (int i = 0; i < got.size() && i < exp_n; i++) if (got[i] != want[i]) bad = 1'b1;
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL repeat_times rel=%0d: got %0d pulses last=%0d want %0d pulses last=%0d",
               rel_k, got.size(), (got.size() > 0) ? got[got.size()-1] : -1, exp_n, want[exp_n-1]);
    end
  endtask

  task automatic test_reset_mid();
    int first_p = -1;
    do_reset();
    btn = 2'b01;
    for (int k = 0; k < 10; k++) tick();
    btn = 2'b11;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (obs_vec(c) !== 6'b0) begin
        n_err++;
        $display("FAIL async_reset u%0d: got %b want %b", c, obs_vec(c), 6'b0);
      end
    end
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (obs_vec(c) !== exp_vec(c)) begin
          n_err++;
          $display("FAIL reset_mid u%0d cyc%0d: got %b want %b", c, k, obs_vec(c), exp_vec(c));
        end
      end
      if (pls[0] == 2'b11 && first_p < 0) first_p = k;
    end
    n_cmp++;
    if (first_p !== 7) begin
      n_err++;
      $display("FAIL held_through_reset: got pulse at %0d want 7", first_p);
    end
  endtask

  task automatic test_random();
    int hold_left[2] = '{0, 0};
    do_reset();
    for (int k = 0; k < 800; k++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (hold_left[ch] == 0) begin
          btn[ch] = $urandom_range(0, 1);
          hold_left[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 60);
        end
        hold_left[ch]--;
      end
      en = ($urandom_range(0, 7) != 0);
      tick();
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (obs_vec(c) !== exp_vec(c)) begin
          n_err++;
          $display("FAIL random u%0d cyc%0d: got %b want %b", c, k + 1, obs_vec(c), exp_vec(c));
        end
      end
    end
    en = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_edge_modes();
    test_simultaneous();
    test_repeat(64, 7);
    test_repeat(40, 4);
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
